// File: rtl/aukv_pkg.sv
// Shared aukv definitions: hazard FSM states, forward-select codes, tracking slots.
package aukv_pkg;

  localparam int REG_W   = 5;
  localparam int NUM_SRC = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_BRFLUSH = 2'd3
  } hz_state_e;

  // Operand source for execute; the execute stage muxes on these same codes.
  typedef enum logic [1:0] {
    FW_RF = 2'd0,
    FW_EE = 2'd1,
    FW_ME = 2'd2
  } fwsel_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    logic             load;
  } ex_slot_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
  } mem_slot_t;

  // The younger producer (EX) always wins over the older one (MEM).
  function automatic fwsel_e fw_pick(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FW_EE;
    else if (mem_hit) return FW_ME;
    else              return FW_RF;
  endfunction

endpackage

// File: rtl/aukv_fwd_cmp.sv
// Slot-vs-source compare: true when a tracked producer writes the register a source reads.
module aukv_fwd_cmp
  import aukv_pkg::*;
(
  input  logic             i_used,
  input  logic [REG_W-1:0] i_addr,
  input  logic [REG_W-1:0] i_slot_rd,
  input  logic             i_slot_we,
  output logic             o_hit
);

  // x0 is hardwired zero, so it never takes a forwarded value.
  assign o_hit = i_used & (i_addr != '0) & i_slot_we & (i_slot_rd == i_addr);

endmodule

// File: rtl/aukv_hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load-use / memory / branch stalls and flushes.
module aukv_hazard_ctrl
  import aukv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1_addr,
  input  logic [REG_W-1:0] i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [REG_W-1:0] i_id_wb_reg,
  input  logic             i_id_wb_we,
  input  logic             i_id_is_load,
  input  logic             i_ex_br_en,
  input  logic             i_dmem_busy,
  input  logic             i_imem_busy,
  output logic [1:0]       o_rs1_fwsel,
  output logic [1:0]       o_rs2_fwsel,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_flush_id,
  output logic             o_flush_ex,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cnt
);

  hz_state_e state, state_nxt;
  ex_slot_t  ex_slot;
  mem_slot_t mem_slot;
  logic      br_pend;
  logic [CNT_W-1:0] stall_cnt;

  logic [NUM_SRC-1:0][REG_W-1:0] src_addr;
  logic [NUM_SRC-1:0]            src_used;
  logic [NUM_SRC-1:0]            ex_hit, mem_hit;
  logic [NUM_SRC-1:0][1:0]       fw_nxt, fw_q;

  logic ld_use, br_act, hold_slots, bubble_ex;
  logic stall_if, stall_id, stall_ex, flush_id, flush_ex;

  assign src_addr = {i_id_rs2_addr, i_id_rs1_addr};
  assign src_used = {i_id_rs2_used, i_id_rs1_used};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    aukv_fwd_cmp u_ex_cmp (
      .i_used    (src_used[s]),
      .i_addr    (src_addr[s]),
      .i_slot_rd (ex_slot.rd),
      .i_slot_we (ex_slot.we),
      .o_hit     (ex_hit[s])
    );
    aukv_fwd_cmp u_mem_cmp (
      .i_used    (src_used[s]),
      .i_addr    (src_addr[s]),
      .i_slot_rd (mem_slot.rd),
      .i_slot_we (mem_slot.we),
      .o_hit     (mem_hit[s])
    );
    assign fw_nxt[s] = fw_pick(ex_hit[s], mem_hit[s]);
  end

  // A branch seen while memory is busy is remembered until EX unfreezes.
  assign br_act = i_ex_br_en | br_pend;
  assign ld_use = i_id_valid & ex_slot.load & (|ex_hit);

  // Priority decode: reset > dmem busy > branch > load-use > imem busy.
  always_comb begin
    state_nxt  = ST_RUN;
    hold_slots = 1'b0;
    bubble_ex  = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    if (i_rst) begin
      hold_slots = 1'b1;
    end else if (i_dmem_busy) begin
      state_nxt  = ST_MEMWAIT;
      hold_slots = 1'b1;
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      stall_ex   = 1'b1;
    end else if (br_act) begin
      state_nxt  = ST_BRFLUSH;
      bubble_ex  = 1'b1;
      flush_id   = 1'b1;
      flush_ex   = 1'b1;
    end else if (ld_use) begin
      state_nxt  = ST_LDSTALL;
      bubble_ex  = 1'b1;
      stall_if   = 1'b1;
      stall_id   = 1'b1;
      flush_ex   = 1'b1;
    end else if (i_imem_busy) begin
      stall_if   = 1'b1;
      flush_id   = 1'b1;
    end
  end

  // State, tracking slots and registered forward selects.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_RUN;
      br_pend  <= 1'b0;
      ex_slot  <= '0;
      mem_slot <= '0;
      fw_q     <= '0;
    end else begin
      state   <= state_nxt;
      br_pend <= i_dmem_busy & (br_pend | i_ex_br_en);
      if (!hold_slots) begin
        mem_slot <= '{rd: ex_slot.rd, we: ex_slot.we};
        if (bubble_ex) begin
          ex_slot <= '0;
          fw_q    <= '0;
        end else begin
          ex_slot <= '{rd: i_id_wb_reg, we: i_id_wb_we & i_id_valid,
                       load: i_id_is_load & i_id_valid};
          fw_q    <= fw_nxt;
        end
      end
    end
  end

  // Saturating count of cycles with any stall asserted.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      stall_cnt <= '0;
    else if ((stall_if | stall_id | stall_ex) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign o_rs1_fwsel = fw_q[0];
  assign o_rs2_fwsel = fw_q[1];
  assign o_stall_if  = stall_if;
  assign o_stall_id  = stall_id;
  assign o_stall_ex  = stall_ex;
  assign o_flush_id  = flush_id;
  assign o_flush_ex  = flush_ex;
  assign o_state     = state;
  assign o_stall_cnt = stall_cnt;

endmodule

// File: tb/tb_aukv_hazard_ctrl.sv
// Bench for aukv_hazard_ctrl: directed vector table, counter saturation, randomized vs model.
module tb_aukv_hazard_ctrl;

  logic       i_clk, i_rst, i_id_valid;
  logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_id_wb_reg;
  logic       i_id_rs1_used, i_id_rs2_used, i_id_wb_we, i_id_is_load;
  logic       i_ex_br_en, i_dmem_busy, i_imem_busy;
  logic [1:0] o_rs1_fwsel, o_rs2_fwsel, o_state;
  logic       o_stall_if, o_stall_id, o_stall_ex, o_flush_id, o_flush_ex;
  logic [15:0] o_stall_cnt;

  int n_chk = 0;
  int n_fail = 0;

  aukv_hazard_ctrl #(.CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rs1_used(i_id_rs1_used), .i_id_rs2_used(i_id_rs2_used),
    .i_id_wb_reg(i_id_wb_reg), .i_id_wb_we(i_id_wb_we), .i_id_is_load(i_id_is_load),
    .i_ex_br_en(i_ex_br_en), .i_dmem_busy(i_dmem_busy), .i_imem_busy(i_imem_busy),
    .o_rs1_fwsel(o_rs1_fwsel), .o_rs2_fwsel(o_rs2_fwsel),
    .o_stall_if(o_stall_if), .o_stall_id(o_stall_id), .o_stall_ex(o_stall_ex),
    .o_flush_id(o_flush_id), .o_flush_ex(o_flush_ex),
    .o_state(o_state), .o_stall_cnt(o_stall_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit rst, v; logic [4:0] r1; bit u1; logic [4:0] r2; bit u2;
    logic [4:0] wb; bit we, ld, br, db, ib;
    bit c; logic [1:0] st; logic [4:0] stf; logic [1:0] f1, f2; int cnt;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit rst, v, input logic [4:0] r1, input bit u1,
                     input logic [4:0] r2, input bit u2, input logic [4:0] wb,
                     input bit we, ld, br, db, ib, c, input logic [1:0] st,
                     input logic [4:0] stf, input logic [1:0] f1, f2, input int cnt);
    vec_t e;
    e.rst = rst; e.v = v; e.r1 = r1; e.u1 = u1; e.r2 = r2; e.u2 = u2;
    e.wb = wb; e.we = we; e.ld = ld; e.br = br; e.db = db; e.ib = ib;
    e.c = c; e.st = st; e.stf = stf; e.f1 = f1; e.f2 = f2; e.cnt = cnt;
    vq.push_back(e);
  endtask

  task automatic drive(input bit rst, v, input logic [4:0] r1, input bit u1,
                       input logic [4:0] r2, input bit u2, input logic [4:0] wb,
                       input bit we, ld, br, db, ib);
    i_rst = rst; i_id_valid = v; i_id_rs1_addr = r1; i_id_rs1_used = u1;
    i_id_rs2_addr = r2; i_id_rs2_used = u2; i_id_wb_reg = wb; i_id_wb_we = we;
    i_id_is_load = ld; i_ex_br_en = br; i_dmem_busy = db; i_imem_busy = ib;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] ctl_now();
    return {o_state, o_stall_if, o_stall_id, o_stall_ex, o_flush_id, o_flush_ex,
            o_rs1_fwsel, o_rs2_fwsel};
  endfunction

  // Reference model: in-flight producers, index 0 = execute, 1 = memory.
  typedef struct { logic [4:0] rd; bit we; bit ld; } prod_t;
  prod_t   m_pipe[2];
  bit      m_brq;
  int      m_st;
  int      m_fw[2];
  int      m_cnt;

  // Forward source = 1 + position of the youngest in-flight writer of addr.
  function automatic int m_src_sel(input logic [4:0] a, input bit used);
    if (!used || a == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (m_pipe[k].we && m_pipe[k].rd == a) return k + 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin m_pipe[k].rd = 0; m_pipe[k].we = 0; m_pipe[k].ld = 0; end
    m_brq = 0; m_st = 0; m_fw[0] = 0; m_fw[1] = 0; m_cnt = 0;
  endtask

  // Evaluate one cycle: return expected outputs for the current inputs, then advance.
  task automatic m_cycle(output logic [10:0] exp_ctl, output int exp_cnt);
    bit ldu, sif, sid, sex, fid, fex;
    int s1, s2;
    s1 = m_src_sel(i_id_rs1_addr, i_id_rs1_used);
    s2 = m_src_sel(i_id_rs2_addr, i_id_rs2_used);
    ldu = i_id_valid && m_pipe[0].ld && (s1 == 1 || s2 == 1);
    {sif, sid, sex, fid, fex} = 5'b0;
    if (i_rst) ;
    else if (i_dmem_busy)            {sif, sid, sex} = 3'b111;
    else if (i_ex_br_en || m_brq)    {fid, fex} = 2'b11;
    else if (ldu)                    {sif, sid, fex} = 3'b111;
    else if (i_imem_busy)            {sif, fid} = 2'b11;
    exp_ctl = {m_st[1:0], sif, sid, sex, fid, fex, m_fw[0][1:0], m_fw[1][1:0]};
    exp_cnt = m_cnt;
    if (i_rst) m_reset();
    else begin
      if ((sif || sid || sex) && m_cnt < 65535) m_cnt++;
      if (i_dmem_busy) begin
        m_st = 2; m_brq = m_brq || i_ex_br_en;
      end else begin
        m_pipe[1] = m_pipe[0];
        if (i_ex_br_en || m_brq || ldu) begin
          m_st = (i_ex_br_en || m_brq) ? 3 : 1;
          m_pipe[0].rd = 0; m_pipe[0].we = 0; m_pipe[0].ld = 0;
          m_fw[0] = 0; m_fw[1] = 0;
        end else begin
          m_st = 0;
          m_fw[0] = s1; m_fw[1] = s2;
          m_pipe[0].rd = i_id_wb_reg;
          m_pipe[0].we = i_id_wb_we && i_id_valid;
          m_pipe[0].ld = i_id_is_load && i_id_valid;
        end
        m_brq = 0;
      end
    end
  endtask

  initial begin
    logic [10:0] e_ctl;
    int e_cnt;
    //  rst v  r1 u1 r2 u2 wb we ld br db ib  c st  stf      f1 f2 cnt
    add(1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 5'b00000, 0, 0, 0);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0); // reset state
    add(0, 1,  1, 1, 2, 1, 5, 1, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0); // ADD x5
    add(0, 1,  5, 1, 3, 1, 8, 1, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0); // uses x5
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 1, 0, 0);
    add(0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0); // ADDI x0
    add(0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0); // reads x0
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0);
    add(0, 1,  0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0); // LW x6
    add(0, 1,  6, 1, 6, 1, 7, 1, 0, 0, 0, 0,  1, 0, 5'b11001, 0, 0, 0); // load-use
    add(0, 1,  6, 1, 6, 1, 7, 1, 0, 0, 0, 0,  1, 1, 5'b00000, 0, 0, 1); // reissue
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 2, 2, 1);
    add(0, 1,  0, 0, 0, 0, 9, 1, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 1); // x9 -> MEM
    add(0, 1,  0, 0, 0, 0, 9, 1, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 1); // x9 -> EX
    add(0, 1,  9, 1, 9, 1, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 1);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 1, 1, 1); // EX wins
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  1, 0, 5'b11100, 0, 0, 1); // busy + br
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 2, 5'b11100, 0, 0, 2);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 2, 5'b11100, 0, 0, 3);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 2, 5'b00011, 0, 0, 4); // held branch
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 5'b00000, 0, 0, 4);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 4);
    add(0, 1,  0, 0, 0, 0,10, 1, 0, 0, 0, 1,  1, 0, 5'b10010, 0, 0, 4); // imem busy
    add(0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 5);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 1, 0, 5);
    add(0, 1,  0, 0, 0, 0,11, 1, 0, 1, 0, 0,  1, 0, 5'b00011, 0, 0, 5); // branch
    add(0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 5'b00000, 0, 0, 5);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 5);
    add(0, 1,  0, 0, 0, 0,12, 1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 5); // LW x12
    add(0, 1, 12, 1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 5'b00011, 0, 0, 5); // ld-use + br
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 3, 5'b00000, 0, 0, 5);
    add(0, 1,  0, 0, 0, 0,13, 1, 1, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 5); // LW x13
    add(0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b11001, 0, 0, 5);
    add(1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 5'b00000, 0, 0, 6); // rst in LDSTALL
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0);
    add(0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0);
    add(0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 5'b00000, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].v, vq[i].r1, vq[i].u1, vq[i].r2, vq[i].u2,
            vq[i].wb, vq[i].we, vq[i].ld, vq[i].br, vq[i].db, vq[i].ib);
      @(negedge i_clk);
      if (vq[i].c) begin
        chk($sformatf("row%0d ctl", i), 32'(ctl_now()),
            32'({vq[i].st, vq[i].stf, vq[i].f1, vq[i].f2}));
        chk($sformatf("row%0d cnt", i), 32'(o_stall_cnt), 32'(vq[i].cnt));
      end
      @(posedge i_clk); #1;
    end

    // Counter saturation under a long memory wait.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge i_clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 65534; i++) @(posedge i_clk);
    @(negedge i_clk);
    chk("sat pre", 32'(o_stall_cnt), 32'hFFFE);
    @(posedge i_clk); @(negedge i_clk);
    chk("sat hit", 32'(o_stall_cnt), 32'hFFFF);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("sat hold", 32'(o_stall_cnt), 32'hFFFF);
    chk("sat state", 32'(o_state), 32'd2);

    // Randomized traffic against the model.
    @(posedge i_clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge i_clk); #1;
    m_reset();
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8,
            5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3);
      @(negedge i_clk);
      m_cycle(e_ctl, e_cnt);
      chk($sformatf("rand%0d ctl", i), 32'(ctl_now()), 32'(e_ctl));
      chk($sformatf("rand%0d cnt", i), 32'(o_stall_cnt), 32'(e_cnt));
      @(posedge i_clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aukv_hazard_ctrl.md
AUKV_HAZARD_CTRL -- requirements
Module: aukv_hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: i_clk (rising edge) and i_rst; no other clock or reset.
REQ-002 Parameter: CNT_W, default 16, width of the stall performance counter.
REQ-003 Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_id_valid  in  1  decode holds a valid instruction
- i_id_rs1_addr, i_id_rs2_addr  in  5 each  decode source registers
- i_id_rs1_used, i_id_rs2_used  in  1 each  source actually read
- i_id_wb_reg  in  5  decode destination
- i_id_wb_we  in  1  decode writes rd
- i_id_is_load  in  1  decode instruction is a load
- i_ex_br_en  in  1  registered taken-branch from the execute stage
- i_dmem_busy  in  1  data memory not ready
- i_imem_busy  in  1  instruction memory not ready
- o_rs1_fwsel, o_rs2_fwsel  out  2 each  forward select to execute: 0 regfile, 1 EX result, 2 MEM result
- o_stall_if, o_stall_id, o_stall_ex  out  1 each  hold stage registers
- o_flush_id, o_flush_ex  out  1 each  bubble stage registers
- o_state  out  2  FSM state
- o_stall_cnt  out  CNT_W  saturating count of stalled cycles

Function
REQ-004 States SHALL be RUN=0, LDSTALL=1, MEMWAIT=2, BRFLUSH=3.
REQ-005 Two tracking slots SHALL be kept: EXslot {rd, we, load} for the instruction now in execute, and MEMslot {rd, we} for the instruction one stage later.
REQ-006 On every non-stalled edge, MEMslot SHALL take EXslot, and EXslot SHALL take decode {wb_reg, wb_we & id_valid, is_load & id_valid}; a bubble sets we=0.
REQ-007 A forward hit SHALL require used=1, addr!=0, slot we=1 and rd==addr; x0 never hits.
REQ-008 The forward select SHALL be computed per source at issue and registered with the ID->EX transfer: EXslot hit gives 1, else MEMslot hit gives 2, else 0; EX beats MEM.
REQ-009 Load-use: an EXslot hit with EXslot load=1 and i_id_valid=1 in RUN SHALL enter LDSTALL for exactly 1 cycle: stall_if=stall_id=1, flush_ex=1, EXslot<=bubble, MEMslot<=EXslot; the select after the stall SHALL be 2.
REQ-010 i_dmem_busy=1 SHALL enter or stay in MEMWAIT: all three stalls high, flushes low, slots and fwsel held; busy low returns to RUN on the next edge.
REQ-011 i_ex_br_en=1 (not busy) SHALL assert flush_id=flush_ex=1 in the same cycle (Mealy), set EXslot<=bubble, MEMslot<=EXslot, and go to BRFLUSH for 1 cycle, then RUN.
REQ-012 Priority SHALL be: reset > dmem_busy > br_en > load-use > imem_busy. A branch during MEMWAIT SHALL be held, because EX is frozen, and acted on in the first non-busy cycle. A load-use during a branch SHALL be discarded.
REQ-013 i_imem_busy=1 in RUN SHALL assert stall_if only and flush_id=1; EX and MEM continue.
REQ-014 o_stall_cnt SHALL increment on each cycle with any stall output high and saturate at all-ones.
REQ-015 Outputs SHALL be a pure function of state and registers, plus the Mealy paths of REQ-009..013; there SHALL be no combinational loop through i_id_*.

Reset
REQ-016 While i_rst=1 at a rising edge: state=RUN, both slots we=0/load=0/rd=0, fwsel=0, o_stall_cnt=0; stall and flush outputs SHALL read 0 in the following cycle.
REQ-017 Reset mid-stall or mid-flush SHALL abandon that stall or flush with no residual bubble.

Structure
REQ-018 The state encodings and the fwsel codes (FW_RF=0, FW_EE=1, FW_ME=2) SHALL be defined in the shared aukv package, and the execute stage SHALL use the same codes.
REQ-019 One sub-module, aukv_fwd_cmp (slot-vs-source hit compare), SHALL be instantiated twice per source; the FSM and counter SHALL stay in the top module.

Verification
REQ-020 ADD x5 then ADD using x5 back-to-back -> rs1_fwsel=1, no stall, o_stall_cnt unchanged.
REQ-021 LW x6 then ADD x7,x6,x6 -> 1 cycle LDSTALL with flush_ex=1, then rs1_fwsel=rs2_fwsel=2, o_stall_cnt=1.
REQ-022 ADDI x0 then a consumer of x0 -> fwsel=0 for both sources.
REQ-023 i_dmem_busy=1 for 3 cycles with i_ex_br_en=1 in the first -> 3 cycles of all stalls, then 1 cycle of flush_id=flush_ex=1, state 2,2,2,3,0.
REQ-024 Producer at x9 in both EX and MEM slots -> fwsel=1 (EX priority).
REQ-025 i_rst asserted during LDSTALL -> next cycle all outputs 0 and state=RUN, and the counter saturates at 0xFFFF after a forced long busy.
